// File: rtl/booth_product_accum_if.sv
// Handshake bundle for the product-accumulate stage:
// product stream in, completed sums out.
interface booth_product_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/booth_product_accum.sv
// Sums N_TERMS signed products into a signed accumulator and
// presents each finished sum with a sticky overflow flag.
module booth_product_accum #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 16,
    parameter int N_TERMS = 4,
    parameter int SAT     = 1
) (
    input logic                 clk,
    input logic                 rst,
    input logic                 clear,
    booth_product_accum_if.slave bus
);
    localparam int CW = $clog2(N_TERMS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_TERMS);
    localparam logic [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    cnt;
    logic             ovf;
    logic             rdy;
    logic             vld;
    logic [ACC_W-1:0] oacc;
    logic             oovf;

    logic [ACC_W-1:0] prod_x;
    logic [ACC_W:0]   sum_w;
    logic             add_ovf;
    logic [ACC_W-1:0] sum_f;
    logic             first;
    logic [ACC_W-1:0] nxt_acc;
    logic             nxt_ovf;
    logic [CW-1:0]    nxt_cnt;
    logic             fin;
    logic             accept;
    logic             emit;

    assign prod_x = ACC_W'($signed(bus.in_prod));
    assign sum_w  = {acc[ACC_W-1], acc} + {prod_x[ACC_W-1], prod_x};

    // Overflow: like-signed operands yielding a differently-signed result
    assign add_ovf = (acc[ACC_W-1] == prod_x[ACC_W-1]) &&
                     (sum_w[ACC_W-1] != acc[ACC_W-1]);

    always_comb begin
        sum_f = sum_w[ACC_W-1:0];
        if (add_ovf && (SAT != 0))
            sum_f = acc[ACC_W-1] ? MINV : MAXV;
    end

    assign first   = (state == IDLE);
    assign nxt_acc = first ? prod_x : sum_f;
    assign nxt_ovf = first ? 1'b0 : (ovf | add_ovf);
    assign nxt_cnt = first ? CW'(1) : cnt + CW'(1);
    assign fin     = (nxt_cnt == LAST);

    assign accept = bus.in_valid & rdy;
    assign emit   = vld & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            rdy   <= 1'b0;
            vld   <= 1'b0;
            oacc  <= '0;
            oovf  <= 1'b0;
        end else if (clear) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            rdy   <= 1'b1;
            vld   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, ACCUM: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        acc <= nxt_acc;
                        ovf <= nxt_ovf;
                        cnt <= nxt_cnt;
                        if (fin) begin
                            state <= DONE;
                            rdy   <= 1'b0;
                            vld   <= 1'b1;
                            oacc  <= nxt_acc;
                            oovf  <= nxt_ovf;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (emit) begin
                        state <= IDLE;
                        vld   <= 1'b0;
                        rdy   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rdy   <= 1'b1;
                    vld   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_acc   = oacc;
    assign bus.out_ovf   = oovf;
endmodule

// File: tb/tb_booth_product_accum.sv
// Bench for booth_product_accum: default instance plus two
// 8-bit accumulators (saturating and wrapping) fed in lockstep.
module tb_booth_product_accum;
    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       iv;
    logic [7:0] ip;
    logic       ordy;

    always #5 clk = ~clk;

    booth_product_accum_if #(.PROD_W(8), .ACC_W(16)) bus ();
    booth_product_accum_if #(.PROD_W(8), .ACC_W(8))  bs ();
    booth_product_accum_if #(.PROD_W(8), .ACC_W(8))  bw ();

    assign bus.in_valid = iv;
    assign bus.in_prod = ip;
    assign bus.out_ready = ordy;
    assign bs.in_valid = iv;
    assign bs.in_prod = ip;
    assign bs.out_ready = ordy;
    assign bw.in_valid = iv;
    assign bw.in_prod = ip;
    assign bw.out_ready = ordy;

    booth_product_accum #(.PROD_W(8), .ACC_W(16), .N_TERMS(4), .SAT(1)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus)
    );
    booth_product_accum #(.PROD_W(8), .ACC_W(8), .N_TERMS(4), .SAT(1)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .bus(bs)
    );
    booth_product_accum #(.PROD_W(8), .ACC_W(8), .N_TERMS(4), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .bus(bw)
    );

    typedef struct {
        logic [3:0][7:0] p;
        int              gap;
        logic [15:0]     acc;
        logic            ovf;
    } vec_t;

    int tests = 0;
    int fails = 0;

    logic [15:0] r16;
    logic        ro16;
    logic [7:0]  r8s;
    logic        ro8s;
    logic [7:0]  r8w;
    logic        ro8w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: clamp or wrap each running sum into w signed bits
    function automatic void model(input logic [3:0][7:0] p, input int w, input bit sat,
                                  output logic [15:0] acc, output logic ovf);
        longint mx, mn, s, a;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -mx - 1;
        a = longint'($signed(p[0]));
        ovf = 1'b0;
        for (int i = 1; i < 4; i++) begin
            s = a + longint'($signed(p[i]));
            if (s > mx) begin
                ovf = 1'b1;
                s = sat ? mx : s - (longint'(1) <<< w);
            end else if (s < mn) begin
                ovf = 1'b1;
                s = sat ? mn : s + (longint'(1) <<< w);
            end
            a = s;
        end
        acc = 16'(a) & 16'((longint'(1) <<< w) - 1);
    endfunction

    task automatic send(input logic [3:0][7:0] p, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            iv = 1'b0;
            repeat (gap * i) begin
                @(negedge clk);
                chk("gap_in_ready", bus.in_ready, 1);
                @(posedge clk);
                #1;
            end
            iv = 1'b1;
            ip = p[i];
            begin
                int k = 0;
                @(negedge clk);
                while (!bus.in_ready && k < 50) begin
                    @(posedge clk);
                    #1;
                    @(negedge clk);
                    k++;
                end
                if (k >= 50) chk("accept_timeout", 0, 1);
            end
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
    endtask

    task automatic collect();
        @(negedge clk);
        chk("latency_out_valid", bus.out_valid, 1);
        r16 = bus.out_acc;
        ro16 = bus.out_ovf;
        r8s = bs.out_acc;
        ro8s = bs.out_ovf;
        r8w = bw.out_acc;
        ro8w = bw.out_ovf;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("valid_one_cycle", bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string nm, input logic [3:0][7:0] p,
                             input logic [15:0] e16, input logic eo16);
        logic [15:0] ea;
        logic        eo;
        chk({nm, "_acc16"}, r16, e16);
        chk({nm, "_ovf16"}, ro16, eo16);
        model(p, 8, 1'b1, ea, eo);
        chk({nm, "_acc8sat"}, r8s, ea);
        chk({nm, "_ovf8sat"}, ro8s, eo);
        model(p, 8, 1'b0, ea, eo);
        chk({nm, "_acc8wrap"}, r8w, ea);
        chk({nm, "_ovf8wrap"}, ro8w, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            tbl[7];
        logic [3:0][7:0] rp;
        logic [15:0]     ea;
        logic            eo;
        logic [15:0]     held;

        tbl[0] = '{{8'hFF, 8'h07, 8'hFB, 8'h03}, 0, 16'h0004, 1'b0};
        tbl[1] = '{{8'h80, 8'h80, 8'h80, 8'h80}, 1, 16'hFE00, 1'b0};
        tbl[2] = '{{8'h04, 8'h03, 8'h02, 8'h01}, 0, 16'h000A, 1'b0};
        tbl[3] = '{{8'h00, 8'hCE, 8'h64, 8'h64}, 0, 16'h0096, 1'b0};
        tbl[4] = '{{8'h7F, 8'h7F, 8'h7F, 8'h7F}, 2, 16'h01FC, 1'b0};
        tbl[5] = '{{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 0, 16'hFFFC, 1'b0};
        tbl[6] = '{{8'h7F, 8'h80, 8'h7F, 8'h80}, 1, 16'hFFFE, 1'b0};

        rst = 1'b1;
        clear = 1'b0;
        iv = 1'b0;
        ip = 8'h00;
        ordy = 1'b1;
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_acc", bus.out_acc, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", bus.in_ready, 1);

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].p, 4, tbl[i].gap);
            collect();
            check_all($sformatf("vec%0d", i), tbl[i].p, tbl[i].acc, tbl[i].ovf);
            if (i == 3) begin
                chk("sat8_100_100_m50_0", {ro8s, r8s}, {1'b1, 8'h4D});
                chk("wrap8_100_100_m50_0", {ro8w, r8w}, {1'b1, 8'h96});
            end
        end

        for (int n = 0; n < 20; n++) begin
            rp = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
            send(rp, 4, $urandom_range(0, 2));
            collect();
            model(rp, 16, 1'b1, ea, eo);
            check_all($sformatf("rand%0d", n), rp, ea, eo);
        end

        ordy = 1'b0;
        rp = {8'h10, 8'hF0, 8'h22, 8'h33};
        send(rp, 4, 0);
        @(negedge clk);
        chk("bp_out_valid", bus.out_valid, 1);
        held = bus.out_acc;
        chk("bp_acc", held, 16'h0055);
        iv = 1'b1;
        ip = 8'h11;
        repeat (5) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_valid_hold", bus.out_valid, 1);
            chk("bp_acc_hold", bus.out_acc, held);
        end
        iv = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_emitted", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rp = {8'h01, 8'h01, 8'h01, 8'h01};
        send(rp, 4, 0);
        collect();
        check_all("bp_fresh", rp, 16'h0004, 1'b0);

        rp = {8'h05, 8'h05, 8'h05, 8'h05};
        send(rp, 2, 0);
        iv = 1'b1;
        ip = 8'h40;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        iv = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", bus.out_valid, 0);
        chk("clr_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rp = {8'h04, 8'h03, 8'h02, 8'h01};
        send(rp, 4, 0);
        collect();
        check_all("clr_next", rp, 16'd10, 1'b0);

        rp = {8'h09, 8'h09, 8'h09, 8'h09};
        send(rp, 2, 0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_accum_valid", bus.out_valid, 0);
        chk("arst_accum_acc", bus.out_acc, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        ordy = 1'b0;
        rp = {8'h7F, 8'h7F, 8'h7F, 8'h7F};
        send(rp, 4, 0);
        @(negedge clk);
        chk("pre_arst_done", {bus.out_valid, bs.out_ovf}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_done_valid", bus.out_valid, 0);
        chk("arst_done_acc", bus.out_acc, 0);
        chk("arst_done_ovf8", bs.out_ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ordy = 1'b1;
        rp = {8'hFF, 8'h07, 8'hFB, 8'h03};
        send(rp, 4, 0);
        collect();
        check_all("post_arst", rp, 16'h0004, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
